// File: rtl/rtc_multi_alarm_if.sv
// Key/control inputs and time/alarm/ring outputs of the RTC core.
interface rtc_multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic                  key_mode;
  logic                  key_up;
  logic                  key_down;
  logic                  set_alarm;
  logic [IDX_W-1:0]      alarm_sel;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  stop;
  logic                  snooze;
  logic [4:0]            hour;
  logic [5:0]            min;
  logic [5:0]            sec;
  logic [4:0]            alm_hour;
  logic [5:0]            alm_min;
  logic [1:0]            edit_field;
  logic                  edit_alarm;
  logic                  tick_1s;
  logic                  ring;
  logic [IDX_W-1:0]      ring_idx;

  modport master (
    output key_mode, key_up, key_down, set_alarm, alarm_sel, alarm_en, stop, snooze,
    input  hour, min, sec, alm_hour, alm_min, edit_field, edit_alarm, tick_1s, ring, ring_idx
  );

  modport slave (
    input  key_mode, key_up, key_down, set_alarm, alarm_sel, alarm_en, stop, snooze,
    output hour, min, sec, alm_hour, alm_min, edit_field, edit_alarm, tick_1s, ring, ring_idx
  );
endinterface

// File: rtl/rtc_multi_alarm.sv
// 24 h real-time clock with several alarms, snooze, bounded ring and key editing.
//
// state  | meaning
// S_RUN  | normal timekeeping, keys other than key_mode ignored
// S_HOUR | editing hour of time or selected alarm
// S_MIN  | editing minute of time or selected alarm
// S_SEC  | editing second of time (alarms have no seconds field)
module rtc_multi_alarm #(
  parameter int CLK_FREQ   = 12000000,
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int RING_SEC   = 10,
  parameter int SNOOZE_MIN = 5
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  rtc_multi_alarm_if.slave bus
);
  localparam int              PW         = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam int              RW         = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0]   RING_LOAD  = RW'(RING_SEC);
  localparam logic [6:0]      SNZ_ADD    = 7'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } edit_state_t;

  edit_state_t      state, state_nx;
  logic             edit_alarm_r, edit_alarm_nx;
  logic [IDX_W-1:0] edit_idx, edit_idx_nx;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [4:0]       hour_r;
  logic [5:0]       min_r;
  logic [5:0]       sec_r;
  logic [4:0]       alm_h [NUM_ALARMS];
  logic [5:0]       alm_m [NUM_ALARMS];
  logic [4:0]       alm_hour_sel;
  logic [5:0]       alm_min_sel;

  logic             min_tick_q;
  logic             match_hit;
  logic             match_snz;
  logic [IDX_W-1:0] match_idx;

  logic             ring_r;
  logic [IDX_W-1:0] ring_idx_r;
  logic [RW-1:0]    ring_cnt;
  logic             snz_valid;
  logic [4:0]       snz_hour;
  logic [5:0]       snz_min;
  logic [IDX_W-1:0] snz_idx;
  logic [6:0]       snz_sum;
  logic [6:0]       snz_wrap;
  logic [4:0]       snz_hour_nx;
  logic [5:0]       snz_min_nx;

  logic             time_edit;
  logic             key_adj;
  logic             key_inc;

  function automatic logic [4:0] wrap24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Editing the time freezes the prescaler; key_mode shadows up/down, up shadows down.
  assign time_edit = (state != S_RUN) && !edit_alarm_r;
  assign key_adj   = (state != S_RUN) && !bus.key_mode && (bus.key_up || bus.key_down);
  assign key_inc   = bus.key_up;
  assign tick      = !time_edit && (presc == PRESC_LAST);

  // Edit FSM state register with the latched edit target.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= S_RUN;
      edit_alarm_r <= 1'b0;
      edit_idx     <= '0;
    end else begin
      state        <= state_nx;
      edit_alarm_r <= edit_alarm_nx;
      edit_idx     <= edit_idx_nx;
    end
  end

  // Edit FSM next state: key_mode walks the fields, alarms skip the seconds field.
  always_comb begin
    state_nx      = state;
    edit_alarm_nx = edit_alarm_r;
    edit_idx_nx   = edit_idx;
    if (bus.key_mode) begin
      case (state)
        S_RUN: begin
          state_nx      = S_HOUR;
          edit_alarm_nx = bus.set_alarm;
          edit_idx_nx   = bus.alarm_sel;
        end
        S_HOUR: state_nx = S_MIN;
        S_MIN: begin
          if (edit_alarm_r) begin
            state_nx      = S_RUN;
            edit_alarm_nx = 1'b0;
          end else begin
            state_nx = S_SEC;
          end
        end
        default: begin
          state_nx      = S_RUN;
          edit_alarm_nx = 1'b0;
        end
      endcase
    end
  end

  // Seconds prescaler, parked at 0 while the time is being edited.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || time_edit) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Timekeeping registers: key edits in time-edit mode, otherwise carry chain on tick.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hour_r <= '0;
      min_r  <= '0;
      sec_r  <= '0;
    end else if (time_edit && key_adj) begin
      case (state)
        S_HOUR:  hour_r <= wrap24(hour_r, key_inc);
        S_MIN:   min_r  <= wrap60(min_r, key_inc);
        S_SEC:   sec_r  <= wrap60(sec_r, key_inc);
        default: ;
      endcase
    end else if (tick) begin
      sec_r <= wrap60(sec_r, 1'b1);
      if (sec_r == 6'd59) begin
        min_r <= wrap60(min_r, 1'b1);
        if (min_r == 6'd59) hour_r <= wrap24(hour_r, 1'b1);
      end
    end
  end

  // Alarm registers, edited only when the edit session targets an alarm.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alm_h[k] <= '0;
        alm_m[k] <= '0;
      end
    end else if (edit_alarm_r && key_adj) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (edit_idx == IDX_W'(k)) begin
          case (state)
            S_HOUR:  alm_h[k] <= wrap24(alm_h[k], key_inc);
            S_MIN:   alm_m[k] <= wrap60(alm_m[k], key_inc);
            default: ;
          endcase
        end
      end
    end
  end

  // Display readback of the alarm picked by alarm_sel; unused indices read 00:00.
  always_comb begin
    alm_hour_sel = '0;
    alm_min_sel  = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (bus.alarm_sel == IDX_W'(k)) begin
        alm_hour_sel = alm_h[k];
        alm_min_sel  = alm_m[k];
      end
    end
  end

  // Remember that the last edge rolled seconds to 0, so the new hh:mm is compared now.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) min_tick_q <= 1'b0;
    else            min_tick_q <= tick && (sec_r == 6'd59);
  end

  // Alarm match: lowest enabled index wins, snooze only when no alarm matches.
  always_comb begin
    match_hit = 1'b0;
    match_snz = 1'b0;
    match_idx = '0;
    if (min_tick_q && !time_edit) begin
      for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
        if (bus.alarm_en[k] && (alm_h[k] == hour_r) && (alm_m[k] == min_r)) begin
          match_hit = 1'b1;
          match_idx = IDX_W'(k);
        end
      end
      if (!match_hit && snz_valid && (snz_hour == hour_r) && (snz_min == min_r)) begin
        match_hit = 1'b1;
        match_snz = 1'b1;
        match_idx = snz_idx;
      end
    end
  end

  // Snooze target time: current hh:mm plus the snooze delay, minute carry into hour.
  always_comb begin
    snz_sum     = {1'b0, min_r} + SNZ_ADD;
    snz_wrap    = snz_sum - 7'd60;
    snz_hour_nx = hour_r;
    snz_min_nx  = snz_sum[5:0];
    if (snz_sum >= 7'd60) begin
      snz_hour_nx = wrap24(hour_r, 1'b1);
      snz_min_nx  = snz_wrap[5:0];
    end
  end

  // Ring control: stop beats snooze, a ring in progress ignores new matches.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ring_r     <= 1'b0;
      ring_idx_r <= '0;
      ring_cnt   <= '0;
      snz_valid  <= 1'b0;
      snz_hour   <= '0;
      snz_min    <= '0;
      snz_idx    <= '0;
    end else if (bus.stop) begin
      ring_r    <= 1'b0;
      snz_valid <= 1'b0;
    end else if (bus.snooze && ring_r) begin
      ring_r    <= 1'b0;
      snz_valid <= 1'b1;
      snz_hour  <= snz_hour_nx;
      snz_min   <= snz_min_nx;
      snz_idx   <= ring_idx_r;
    end else if (ring_r) begin
      if (tick) begin
        if (ring_cnt == RW'(1)) ring_r <= 1'b0;
        ring_cnt <= ring_cnt - RW'(1);
      end
    end else if (match_hit) begin
      ring_r     <= 1'b1;
      ring_idx_r <= match_idx;
      ring_cnt   <= RING_LOAD;
      if (match_snz) snz_valid <= 1'b0;
    end
  end

  assign bus.hour       = hour_r;
  assign bus.min        = min_r;
  assign bus.sec        = sec_r;
  assign bus.alm_hour   = alm_hour_sel;
  assign bus.alm_min    = alm_min_sel;
  assign bus.edit_field = state;
  assign bus.edit_alarm = edit_alarm_r;
  assign bus.tick_1s    = tick;
  assign bus.ring       = ring_r;
  assign bus.ring_idx   = ring_idx_r;
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm at CLK_FREQ=10, RING_SEC=10, SNOOZE_MIN=5.
module tb_rtc_multi_alarm;
  localparam int NA = 4;
  localparam int IW = 2;

  localparam logic [4:0] K_MODE = 5'b10000;
  localparam logic [4:0] K_UP   = 5'b01000;
  localparam logic [4:0] K_DN   = 5'b00100;
  localparam logic [4:0] K_STOP = 5'b00010;
  localparam logic [4:0] K_SNZ  = 5'b00001;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   total      = 0;
  int   bad        = 0;
  int   edit_ticks = 0;

  rtc_multi_alarm_if #(.NUM_ALARMS(NA), .IDX_W(IW)) bus ();

  rtc_multi_alarm #(
    .CLK_FREQ(10), .NUM_ALARMS(NA), .IDX_W(IW), .RING_SEC(10), .SNOOZE_MIN(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Ticks must never appear while the time itself is being edited.
  always @(negedge sys_clk)
    if (bus.tick_1s && bus.edit_field != 2'd0 && !bus.edit_alarm) edit_ticks++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic press(input logic [4:0] v, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {bus.key_mode, bus.key_up, bus.key_down, bus.stop, bus.snooze} = v;
      cyc();
      {bus.key_mode, bus.key_up, bus.key_down, bus.stop, bus.snooze} = 5'b0;
    end
  endtask

  function automatic int hms();
    return int'(bus.hour) * 10000 + int'(bus.min) * 100 + int'(bus.sec);
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick_1s && n < 50);
  endtask

  // lat = negedges from the tick that rolled seconds to 0 until ring is seen high.
  task automatic wait_ring(input int limit, output int lat, output bit seen);
    int cnt;
    int n;
    cnt  = 1000;
    n    = 0;
    lat  = -1;
    seen = 1'b0;
    while (n < limit) begin
      cyc();
      n++;
      cnt++;
      if (bus.ring) begin
        seen = 1'b1;
        lat  = cnt;
        break;
      end
      if (bus.tick_1s && bus.sec == 6'd59) cnt = 0;
    end
  endtask

  initial begin
    int n;
    int gap_bad;
    int lat;
    bit seen;
    int rticks;

    {bus.key_mode, bus.key_up, bus.key_down, bus.stop, bus.snooze} = 5'b0;
    bus.set_alarm = 1'b0;
    bus.alarm_sel = '0;
    bus.alarm_en  = '0;

    // reset state
    repeat (3) cyc();
    chk("rst_time", hms(), 0);
    chk("rst_field", bus.edit_field, 0);
    chk("rst_ealm", bus.edit_alarm, 0);
    chk("rst_ring", bus.ring, 0);
    chk("rst_ridx", bus.ring_idx, 0);
    chk("rst_tick", bus.tick_1s, 0);
    bus.alarm_sel = 2'd3;
    #1;
    chk("rst_alm", {bus.alm_hour, bus.alm_min}, 0);

    // free run: ticks every 10 cycles, 00:01:00 after 60 ticks
    sys_rst_n = 1'b1;
    wait_tick(n);
    chk("first_tick", n, 9);
    gap_bad = 0;
    repeat (59) begin
      wait_tick(n);
      if (n != 10) gap_bad++;
    end
    chk("tick_gap", gap_bad, 0);
    cyc();
    chk("t_000100", hms(), 100);

    // preload 23:59:59 by wrapping downwards, then roll over
    press(K_MODE);
    chk("field_hour", bus.edit_field, 1);
    press(K_DN);
    press(K_MODE);
    press(K_DN, 2);
    press(K_MODE);
    press(K_DN);
    press(K_MODE);
    chk("field_run", bus.edit_field, 0);
    chk("t_235959", hms(), 235959);
    wait_tick(n);
    chk("tick_exit1", n, 9);
    cyc();
    chk("t_rollover", hms(), 0);

    // directed time edit -> 03:58:01
    press(K_MODE);
    chk("ef1", bus.edit_field, 1);
    press(K_UP, 3);
    press(K_MODE);
    chk("ef2", bus.edit_field, 2);
    press(K_DN, 2);
    press(K_MODE);
    chk("ef3", bus.edit_field, 3);
    press(K_UP);
    press(K_MODE);
    chk("ef0", bus.edit_field, 0);
    chk("t_035801", hms(), 35801);
    wait_tick(n);
    chk("tick_exit2", n, 9);
    cyc();
    chk("t_035802", hms(), 35802);

    // alarms 1 and 3 -> 00:01; mode beats up, up beats down
    bus.set_alarm = 1'b1;
    bus.alarm_sel = 2'd1;
    press(K_MODE);
    chk("ealm_flag", bus.edit_alarm, 1);
    press(K_MODE);
    press(K_UP);
    press(K_MODE);
    chk("alm_min_exit", bus.edit_field, 0);
    chk("alm1_rb", int'(bus.alm_hour) * 100 + int'(bus.alm_min), 1);
    bus.alarm_sel = 2'd3;
    press(K_MODE);
    press(K_MODE | K_UP);
    chk("mode_prio_ef", bus.edit_field, 2);
    chk("mode_prio_hr", bus.alm_hour, 0);
    press(K_UP | K_DN);
    press(K_MODE);
    chk("updn_prio", bus.alm_min, 1);
    chk("alm_edit_runs", hms(), 35802);

    // time -> 00:00:58, both alarms fire at 00:01, lowest index wins
    bus.set_alarm = 1'b0;
    bus.alarm_en  = 4'b1010;
    press(K_MODE);
    press(K_DN, 3);
    press(K_MODE);
    press(K_UP, 2);
    press(K_MODE);
    press(K_DN, 4);
    press(K_MODE);
    chk("t_000058", hms(), 58);
    wait_ring(40, lat, seen);
    chk("ringB_seen", seen, 1);
    chk("ringB_lat", lat, 2);
    chk("ringB_idx", bus.ring_idx, 1);
    chk("ringB_time", hms(), 100);

    // enable drop does not stop ring; ring lasts 10 ticks
    bus.alarm_en = 4'b0000;
    rticks = 0;
    n = 0;
    while (bus.ring && n < 200) begin
      if (bus.tick_1s) rticks++;
      cyc();
      n++;
    end
    chk("ring_ticks", rticks, 10);
    chk("ring_end", hms(), 110);

    // alarm 2 enabled, alarm 0 disabled, both 00:02
    bus.set_alarm = 1'b1;
    bus.alarm_sel = 2'd2;
    press(K_MODE, 2);
    press(K_UP, 2);
    press(K_MODE);
    bus.alarm_sel = 2'd0;
    press(K_MODE, 2);
    press(K_UP, 2);
    press(K_MODE);
    bus.alarm_en = 4'b0100;
    wait_ring(700, lat, seen);
    chk("ringA_seen", seen, 1);
    chk("ringA_lat", lat, 2);
    chk("ringA_idx", bus.ring_idx, 2);
    chk("ringA_time", hms(), 200);

    // ringing and in MIN field: glitch ignored, real reset clears all
    press(K_MODE, 2);
    chk("d_field", bus.edit_field, 2);
    chk("d_ring", bus.ring, 1);
    #2 sys_rst_n = 1'b0;
    #2 sys_rst_n = 1'b1;
    cyc();
    chk("glitch_ring", bus.ring, 1);
    chk("glitch_field", bus.edit_field, 2);
    sys_rst_n = 1'b0;
    bus.alarm_sel = 2'd2;
    cyc();
    chk("rst2_time", hms(), 0);
    chk("rst2_ring", bus.ring, 0);
    chk("rst2_ridx", bus.ring_idx, 0);
    chk("rst2_field", bus.edit_field, 0);
    chk("rst2_ealm", bus.edit_alarm, 0);
    chk("rst2_tick", bus.tick_1s, 0);
    chk("rst2_alm", {bus.alm_hour, bus.alm_min}, 0);
    sys_rst_n = 1'b1;
    bus.set_alarm = 1'b0;
    bus.alarm_en  = 4'b0000;

    // time 00:57:58, alarm 1 at 00:58, snooze re-rings at 01:03
    press(K_MODE, 2);
    press(K_DN, 3);
    press(K_MODE);
    press(K_DN, 2);
    press(K_MODE);
    chk("t_005758", hms(), 5758);
    bus.set_alarm = 1'b1;
    bus.alarm_sel = 2'd1;
    press(K_MODE, 2);
    press(K_DN, 2);
    press(K_MODE);
    chk("alm1_58", bus.alm_min, 58);
    bus.alarm_en = 4'b0010;
    wait_ring(100, lat, seen);
    chk("ringC_seen", seen, 1);
    chk("ringC_lat", lat, 2);
    chk("ringC_idx", bus.ring_idx, 1);
    chk("ringC_time", hms(), 5800);
    repeat (2) cyc();
    press(K_SNZ);
    chk("snooze_off", bus.ring, 0);
    wait_ring(3400, lat, seen);
    chk("snz_seen", seen, 1);
    chk("snz_lat", lat, 2);
    chk("snz_idx", bus.ring_idx, 1);
    chk("snz_time", hms(), 10300);
    press(K_STOP | K_SNZ);
    chk("stop_off", bus.ring, 0);
    wait_ring(3400, lat, seen);
    chk("no_rering", seen, 0);

    chk("edit_ticks", edit_ticks, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_multi_alarm.md
Name: rtc_multi_alarm

Overview:
Parametrised real-time clock core: 24 h hh:mm:ss timekeeping, NUM_ALARMS independent alarm registers, and key-driven edit of the time or any alarm.
- Adds snooze, bounded ring duration and per-alarm enables.
- Takes debounced key pulses from the KEY instances.
- Feeds binary time/alarm fields to the BCD/OLED path, and ring/ring_idx to the music player and LED.

Parameters:
CLK_FREQ, 12000000, sys_clk cycles per second (>=2)
NUM_ALARMS, 4, number of alarm channels (1..2**IDX_W)
IDX_W, 2, width of alarm index buses
RING_SEC, 10, ring length in seconds (>=1)
SNOOZE_MIN, 5, snooze delay in minutes (1..59)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; synchronous, active-low, sampled on rising sys_clk
key_mode  in  1  one-cycle pulse: enter or advance edit field
key_up  in  1  one-cycle pulse: increment field being edited
key_down  in  1  one-cycle pulse: decrement field being edited
set_alarm  in  1  edit target select: 0 = time, 1 = alarm
alarm_sel  in  IDX_W  alarm to edit and to display
alarm_en  in  NUM_ALARMS  per-alarm enable, level
stop  in  1  pulse: silence ring, cancel pending snooze
snooze  in  1  pulse: silence ring, re-arm SNOOZE_MIN minutes later
hour  out  5  current hour 0..23
min  out  6  current minute 0..59
sec  out  6  current second 0..59
alm_hour  out  5  hour of alarm alarm_sel (combinational read)
alm_min  out  6  minute of alarm alarm_sel
edit_field  out  2  0 run, 1 hour, 2 min, 3 sec
edit_alarm  out  1  1 = current edit targets an alarm
tick_1s  out  1  one-cycle pulse per second
ring  out  1  alarm sounding
ring_idx  out  IDX_W  alarm that caused ring

Behaviour:
- Reset values: all outputs, time, alarm registers (00:00), prescaler and snooze_valid are 0.
- alm_* is combinational and reflects its reset contents (00:00).
- Prescaler runs 0..CLK_FREQ-1. tick_1s=1 in the cycle the count equals CLK_FREQ-1.
- On tick: sec+1; 59->0 carries to min; min 59->0 carries to hour; hour 23->0. Time registers update on the same clock edge as the tick.
- Edit FSM states: RUN, HOUR, MIN, SEC.
  - RUN --key_mode--> HOUR. set_alarm and alarm_sel are latched on this edge as edit_alarm/edit_idx.
  - HOUR->MIN.
  - MIN->SEC if time target; MIN->RUN if alarm target.
  - SEC->RUN.
- Time edit (HOUR/MIN/SEC, edit_alarm=0):
  - Prescaler held at 0 and tick_1s suppressed.
  - On return to RUN, counting restarts from 0, so the first tick comes CLK_FREQ cycles later.
- Alarm edit: timekeeping continues normally.
- key_up/key_down modify the selected field with modular wrap: 23<->0 for hour, 59<->0 for min/sec. Ignored in RUN.
- Same-cycle key priority: key_mode > key_up > key_down. Lower-priority pulses are dropped.
- Alarm match: evaluated on the edge where a tick sets sec to 0.
  - Candidate k: alarm_en[k]=1 and alarm k equals the new hh:mm.
  - Snooze candidate: snooze_valid and snooze hh:mm equal the new hh:mm.
  - Suppressed during time edit.
  - Lowest alarm index wins; snooze loses to any alarm.
  - ring=1 and ring_idx set on the next edge (1-cycle latency after the tick).
- Ringing:
  - A ring counter loads RING_SEC and decrements on each tick; ring clears on the edge where the counter reaches 0.
  - Matches while ring=1 are ignored.
  - snooze_valid clears when the snooze fires.
- stop: ring=0 and snooze_valid=0 on the next edge.
- snooze while ring=1:
  - ring=0, snooze_valid=1.
  - snooze time = current hh:mm + SNOOZE_MIN, with minute >=60 wrapping -60 and carrying to hour mod 24.
  - The snooze entry remembers ring_idx.
- snooze while ring=0: ignored.
- stop and snooze in the same cycle: stop wins.
- alarm_en[k] falling does not stop a ring already in progress.
- sys_rst_n low mid-edit or mid-ring: everything returns to reset values on that edge.

Test Plan:
- CLK_FREQ=10, reset, run 600 cycles -> tick_1s every 10 cycles; time 00:01:00 after the 60th tick; hour rolls 23:59:59->00:00:00 (preload via edit).
- Time edit: key_mode, 3x key_up, key_mode, 2x key_down, key_mode, key_up, key_mode -> 03:58:01 and edit_field returns 0. No ticks during edit; first tick exactly 10 cycles after exit.
- Alarm 2 set 00:02 and enabled, alarm 0 set 00:02 and disabled -> ring rises 1 cycle after the 00:02:00 tick with ring_idx=2. Ring falls after RING_SEC=10 ticks.
- Alarms 1 and 3 both at 00:01 and enabled -> ring_idx=1. Simultaneous key_up+key_down during edit -> only increment applied.
- Ring at 00:58 from alarm 1, snooze pulse (SNOOZE_MIN=5) -> ring=0; re-rings at 01:03:00 with ring_idx=1. Stop during the second ring -> ring=0 and no further ring.
- Assert sys_rst_n=0 for one cycle while ring=1 and in the MIN field -> all outputs 0 on the next edge. Asynchronous reset glitch between edges -> no effect.
